// File: rtl/text_line_reader_pkg.sv
// Shared definitions for the text line reader and the buffer writer: scan FSM
// encoding and the legal character range.
package text_line_reader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int CHAR_MAX   = 69;
   localparam int CHAR_BLANK = 0;

endpackage

// File: rtl/text_line_reader_cursor_blink.sv
// Cursor blink generator: counts completed scans and toggles the blink phase
// every BLINK_FRAMES scans. Only instantiated when CURSOR_BLINK_EN is defined.
module cursor_blink
   import text_line_reader_pkg::*;
#(
   parameter int BLINK_FRAMES = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic frame_done,
   output logic phase
);

   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (frame_done) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/text_line_reader.sv
// Scans one line of the character buffer and streams it out with a valid/ready
// handshake, flagging the last column and the edit cursor (blink via CURSOR_BLINK_EN).
module text_line_reader
   import text_line_reader_pkg::*;
#(
   parameter int DATA_WIDTH   = 7,
   parameter int ADDR_WIDTH   = 5,
   parameter int LINE_LEN     = 30,
   parameter int BLINK_FRAMES = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] count,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_char,
   output logic [ADDR_WIDTH-1:0] out_col,
   output logic                  out_last,
   output logic                  out_cursor,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_WIDTH-1:0] LAST_MAX = ADDR_WIDTH'(LINE_LEN - 1);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   col_q, col_d;
   logic [ADDR_WIDTH-1:0]   last_idx_q, last_idx_d;
   logic                    cursor_ok_q, cursor_ok_d;
   logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
   logic [DATA_WIDTH-1:0]   out_char_q, out_char_d;
   logic [ADDR_WIDTH-1:0]   out_col_q, out_col_d;
   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q, out_last_d;
   logic                    out_cursor_q, out_cursor_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    blink_phase;

   // Codes outside the character set are shown as blanks.
   function automatic logic [DATA_WIDTH-1:0] clamp_char(input logic [DATA_WIDTH-1:0] c);
      return (c > DATA_WIDTH'(CHAR_MAX)) ? DATA_WIDTH'(CHAR_BLANK) : c;
   endfunction

`ifdef CURSOR_BLINK_EN
   cursor_blink #(
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_cursor_blink (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_done (done_q),
      .phase      (blink_phase)
   );
`else
   assign blink_phase = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      last_idx_d   = last_idx_q;
      cursor_ok_d  = cursor_ok_q;
      rd_addr_d    = rd_addr_q;
      out_char_d   = out_char_q;
      out_col_d    = out_col_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      out_cursor_d = out_cursor_q;
      done_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               last_idx_d  = (count > LAST_MAX) ? LAST_MAX : count;
               cursor_ok_d = (count <= LAST_MAX);
               col_d       = '0;
               rd_addr_d   = '0;
               state_d     = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            out_char_d   = clamp_char(rd_data);
            out_col_d    = col_q;
            out_last_d   = (col_q == last_idx_q);
            out_cursor_d = (col_q == last_idx_q) && cursor_ok_q && blink_phase;
            out_valid_d  = 1'b1;
            state_d      = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (col_q == last_idx_q) begin
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  col_d     = col_q + ADDR_WIDTH'(1);
                  rd_addr_d = col_q + ADDR_WIDTH'(1);
                  state_d   = ISSUE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         col_q        <= '0;
         last_idx_q   <= '0;
         cursor_ok_q  <= 1'b0;
         rd_addr_q    <= '0;
         out_char_q   <= '0;
         out_col_q    <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_cursor_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         last_idx_q   <= last_idx_d;
         cursor_ok_q  <= cursor_ok_d;
         rd_addr_q    <= rd_addr_d;
         out_char_q   <= out_char_d;
         out_col_q    <= out_col_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_cursor_q <= out_cursor_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign rd_addr    = rd_addr_q;
   assign out_char   = out_char_q;
   assign out_col    = out_col_q;
   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign out_cursor = out_cursor_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_text_line_reader.sv
// Directed bench for text_line_reader: synchronous buffer model, handshake
// capture per scan, hand-computed expectations (blink scenario under CURSOR_BLINK_EN).
module tb_text_line_reader;

   localparam int BF = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [4:0] count;
   logic [4:0] rd_addr;
   logic [6:0] rd_data = '0;
   logic       out_valid;
   logic       out_ready;
   logic [6:0] out_char;
   logic [4:0] out_col;
   logic       out_last;
   logic       out_cursor;
   logic       busy;
   logic       done;

   logic [6:0] mem [32];

   int n_tests = 0;
   int n_fail  = 0;

   int         cap_n, first_valid, done_cnt, done_at, last_hs, scans, sb;
   logic       busy_ok;
   logic [6:0] cap_char [32];
   logic [4:0] cap_col  [32];
   logic       cap_last [32];
   logic       cap_cur  [32];
   int         cap_k    [32];

   text_line_reader #(
      .DATA_WIDTH   (7),
      .ADDR_WIDTH   (5),
      .LINE_LEN     (30),
      .BLINK_FRAMES (BF)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .count      (count),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_char   (out_char),
      .out_col    (out_col),
      .out_last   (out_last),
      .out_cursor (out_cursor),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_data <= mem[rd_addr];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic exp_phase(input int s);
`ifdef CURSOR_BLINK_EN
      return ((s / BF) % 2) == 1;
`else
      return 1'b1;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Samples on falling edges until the scan has ended and the block is idle again.
   task automatic collect(input int max_cyc);
      cap_n = 0; first_valid = -1; done_cnt = 0; done_at = -1; last_hs = -1; busy_ok = 1'b1;
      for (int k = 1; k <= max_cyc; k++) begin
         if (out_valid && first_valid < 0) first_valid = k;
         if (done_at < 0 && !busy) busy_ok = 1'b0;
         if (done) begin done_cnt++; done_at = k; scans++; end
         if (out_valid && out_ready && cap_n < 32) begin
            cap_char[cap_n] = out_char; cap_col[cap_n] = out_col;
            cap_last[cap_n] = out_last; cap_cur[cap_n] = out_cursor;
            cap_k[cap_n] = k; last_hs = k; cap_n++;
         end
         if (done_at >= 0 && !busy && !done) break;
         @(negedge clk);
      end
   endtask

   task automatic do_scan(input int max_cyc);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      collect(max_cyc);
   endtask

   initial begin
      logic [31:0] m_last, m_cur, m_exp;
      logic        ok, stable;
      logic [14:0] snap;

      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; count = '0; scans = 0;
      for (int i = 0; i < 32; i++) mem[i] = 7'd0;
      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_outs", {out_char, out_col, out_last, out_cursor, rd_addr}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Three-character line with cursor on the last column
      mem[0] = 7'd5; mem[1] = 7'd6; mem[2] = 7'd7;
      count = 5'd2; out_ready = 1'b1; sb = scans;
      do_scan(60);
      chk("a_n", cap_n, 3);
      chk("a_chars", {cap_char[0], cap_char[1], cap_char[2]}, {7'd5, 7'd6, 7'd7});
      chk("a_cols", {cap_col[0], cap_col[1], cap_col[2]}, {5'd0, 5'd1, 5'd2});
      chk("a_last", {cap_last[2], cap_last[1], cap_last[0]}, 3'b100);
      chk("a_cursor", {cap_cur[2], cap_cur[1], cap_cur[0]}, {exp_phase(sb), 2'b00});
      chk("a_first_valid", first_valid, 3);
      chk("a_rate", cap_k[1] - cap_k[0], 3);
      chk("a_done_cnt", done_cnt, 1);
      chk("a_done_gap", done_at - last_hs, 1);
      chk("a_busy", busy_ok, 1);

      // Single-character line
      mem[0] = 7'd9; count = 5'd0; sb = scans;
      do_scan(30);
      chk("b_n", cap_n, 1);
      chk("b_char_col", {cap_char[0], cap_col[0]}, {7'd9, 5'd0});
      chk("b_last", cap_last[0], 1);
      chk("b_cursor", cap_cur[0], exp_phase(sb));
      chk("b_first_valid", first_valid, 3);

      // Count beyond the line clamps to the last column, no cursor
      for (int i = 0; i < 30; i++) mem[i] = 7'(i + 40);
      mem[30] = 7'd99; mem[31] = 7'd99;
      count = 5'd31;
      do_scan(200);
      chk("c_n", cap_n, 30);
      ok = 1'b1; m_last = '0; m_cur = '0;
      for (int i = 0; i < 30; i++) begin
         if (cap_char[i] !== 7'(i + 40) || cap_col[i] !== 5'(i)) ok = 1'b0;
         m_last[i] = cap_last[i];
         m_cur[i]  = cap_cur[i];
      end
      chk("c_data", ok, 1);
      chk("c_last", m_last, 32'h2000_0000);
      chk("c_cursor", m_cur, 0);
      chk("c_done_cnt", done_cnt, 1);

      // Backpressure, ignored restart, mid-scan count change, out-of-range code
      mem[0] = 7'd100; mem[1] = 7'd42; count = 5'd1; out_ready = 1'b0; sb = scans;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("d_valid", out_valid, 1);
      chk("d_clamp", out_char, 0);
      snap = {out_char, out_col, out_last, out_cursor, out_valid};
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         start = (i == 2);
         if (i == 4) count = 5'd7;
         @(negedge clk);
         if ({out_char, out_col, out_last, out_cursor, out_valid} !== snap) stable = 1'b0;
      end
      start = 1'b0;
      chk("d_stable", stable, 1);
      out_ready = 1'b1;
      collect(40);
      chk("d_n", cap_n, 2);
      chk("d_chars", {cap_char[0], cap_char[1]}, {7'd0, 7'd42});
      chk("d_last", {cap_last[1], cap_last[0]}, 2'b10);
      chk("d_cursor", cap_cur[1], exp_phase(sb));
      chk("d_done_cnt", done_cnt, 1);
      repeat (5) @(negedge clk);
      chk("d_idle_after", {busy, out_valid}, 0);

      // Reset asserted while column 3 is presented
      for (int i = 0; i < 8; i++) mem[i] = 7'(i + 1);
      count = 5'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid && out_col == 5'd3) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("e_reached_col3", ok, 1);
      rst_n = 1'b0;
      #1;
      chk("e_async_clear", {out_valid, out_char, out_col, out_last, out_cursor, busy, done, rd_addr}, 0);
      scans = 0;
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done || busy) ok = 1'b0;
      end
      chk("e_no_done", ok, 1);
      count = 5'd1;
      do_scan(40);
      chk("e_n", cap_n, 2);
      chk("e_restart", {cap_col[0], cap_char[0]}, {5'd0, 7'd1});

`ifdef CURSOR_BLINK_EN
      // Blink phase over five consecutive scans from reset
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; scans = 0;
      @(negedge clk);
      count = 5'd0; mem[0] = 7'd1; m_cur = '0;
      for (int s = 0; s < 5; s++) begin
         do_scan(30);
         m_cur[s] = cap_cur[0];
      end
      chk("f_blink", m_cur, 32'b01100);
`endif

      m_exp = 0;
      chk("end_idle", {busy, done, out_valid}, m_exp[2:0]);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
